// File: rtl/out_port_fifo.sv
// Output-port FIFO between the ALU datapath and the peripherals: OUT writes are
// queued as {port, data}, drained by valid/ready, and dropped (with a sticky flag) when full.
module out_port_fifo #(
  parameter int DW    = 8,
  parameter int PAW   = 2,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           wr_en,
  input  logic [PAW-1:0] wr_port,
  input  logic [DW-1:0]  wr_data,
  output logic           full,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [PAW-1:0] out_port,
  output logic [DW-1:0]  out_data,
  output logic [CW-1:0]  count,
  output logic           ovf_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PAW+DW-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              push, pop;

  // Status decoded from registered occupancy only, so the CPU side sees no comb path.
  assign full      = (count_q == FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = wr_en & ~full;
  assign pop       = out_valid & out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    // Pointers are AW bits wide, so +1 wraps modulo DEPTH (power of two).
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (wr_en && full) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is deliberately not cleared on reset; the pointers alone define contents.
  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= {wr_port, wr_data};
  end

  assign {out_port, out_data} = mem_q[rd_ptr_q];
  assign count                = count_q;
  assign ovf_err              = ovf_q;

endmodule
